// File: rtl/game_controller_p.sv
// game_controller_p
// Round-based game control FSM. It drives the datapath command strobes and
// runs the user-turn timeout, round counting, win detection, multi-life retry
// and enter rising-edge detection internally.
//
// Ports:
//   clock_50            system clock, rising edge
//   reset               asynchronous, active-low
//   enter               start/restart key (level, already synchronised)
//   end_fpga, end_user  datapath sequence-shown / user-entry-done flags
//   match               user entry equals sequence (looked at in CHECK only)
//   r1, r2              global / per-round datapath resets
//   e1..e4              setup / user-play / fpga-play / check enables
//   sel                 result display select
//   round               rounds completed in the current game
//   lives_left          attempts remaining
//   timer               cycles elapsed in the current user turn
//   won                 last game won (meaningful in RESULT)
module game_controller_p #(
    parameter int MAX_ROUNDS = 16,
    parameter int ROUND_W    = 5,
    parameter int TIMEOUT    = 250_000_000,
    parameter int TIME_W     = 28,
    parameter int LIVES      = 1
) (
    input  logic               clock_50,
    input  logic               reset,
    input  logic               enter,
    input  logic               end_fpga,
    input  logic               end_user,
    input  logic               match,
    output logic               r1,
    output logic               r2,
    output logic               e1,
    output logic               e2,
    output logic               e3,
    output logic               e4,
    output logic               sel,
    output logic [ROUND_W-1:0] round,
    output logic [2:0]         lives_left,
    output logic [TIME_W-1:0]  timer,
    output logic               won
);

    typedef enum logic [2:0] {
        INIT       = 3'd0,
        SETUP      = 3'd1,
        PLAY_FPGA  = 3'd2,
        PLAY_USER  = 3'd3,
        CHECK      = 3'd4,
        NEXT_ROUND = 3'd5,
        RETRY      = 3'd6,
        RESULT     = 3'd7
    } state_t;

    localparam logic [ROUND_W-1:0] MAX_R    = ROUND_W'(MAX_ROUNDS);
    localparam logic [TIME_W-1:0]  T_LAST   = TIME_W'(TIMEOUT - 1);
    localparam logic [2:0]         LIVES_V  = 3'(LIVES);

    state_t state, state_nxt;
    logic   enter_q;
    logic   enter_rise;
    logic   time_up;
    logic   last_life;

    assign enter_rise = enter & ~enter_q;
    assign time_up    = (timer == T_LAST);
    assign last_life  = (lives_left <= 3'd1);

    // Next state and Moore command decode.
    always_comb begin
        state_nxt = state;
        r1 = 1'b0;
        r2 = 1'b0;
        e1 = 1'b0;
        e2 = 1'b0;
        e3 = 1'b0;
        e4 = 1'b0;
        sel = 1'b0;
        case (state)
            INIT: begin
                r1 = 1'b1;
                r2 = 1'b1;
                state_nxt = SETUP;
            end
            SETUP: begin
                e1 = 1'b1;
                if (enter_rise) state_nxt = PLAY_FPGA;
            end
            PLAY_FPGA: begin
                e3 = 1'b1;
                if (end_fpga) state_nxt = PLAY_USER;
            end
            PLAY_USER: begin
                e2 = 1'b1;
                // Timeout wins over a late end_user in the same cycle.
                if (time_up)       state_nxt = last_life ? RESULT : RETRY;
                else if (end_user) state_nxt = CHECK;
            end
            CHECK: begin
                e4 = 1'b1;
                if (match) state_nxt = NEXT_ROUND;
                else       state_nxt = last_life ? RESULT : RETRY;
            end
            NEXT_ROUND: begin
                r2 = 1'b1;
                state_nxt = (round + ROUND_W'(1) == MAX_R) ? RESULT : PLAY_FPGA;
            end
            RETRY: begin
                r2 = 1'b1;
                state_nxt = PLAY_FPGA;
            end
            RESULT: begin
                sel = 1'b1;
                if (enter_rise) state_nxt = INIT;
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) state <= INIT;
        else        state <= state_nxt;
    end

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            enter_q    <= 1'b0;
            timer      <= '0;
            round      <= '0;
            lives_left <= LIVES_V;
            won        <= 1'b0;
        end else begin
            enter_q <= enter;
            // Count only while staying in the user turn; any exit clears it.
            timer <= (state == PLAY_USER && state_nxt == PLAY_USER) ?
                     timer + TIME_W'(1) : '0;
            case (state)
                INIT: begin
                    round      <= '0;
                    lives_left <= LIVES_V;
                    won        <= 1'b0;
                end
                PLAY_USER, CHECK: begin
                    // Last life lost: game over.
                    if (state_nxt == RESULT) begin
                        won        <= 1'b0;
                        lives_left <= 3'd0;
                    end
                end
                NEXT_ROUND: begin
                    if (round != MAX_R) round <= round + ROUND_W'(1);
                    if (state_nxt == RESULT) won <= 1'b1;
                end
                RETRY: lives_left <= lives_left - 3'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_controller_p.sv
module tb_game_controller_p;

    localparam int MR = 3;
    localparam int TO = 20;

    logic clock_50 = 1'b0;
    logic reset = 1'b1;
    logic enter = 1'b0, end_fpga = 1'b0, end_user = 1'b0, match = 1'b0;

    // cmd = {r1, r2, e1, e2, e3, e4, sel}
    logic [6:0] cmd0, cmd1;
    logic [4:0] rnd0, rnd1;
    logic [2:0] lv0, lv1;
    logic [7:0] tmr0, tmr1;
    logic       won0, won1;

    int total = 0;
    int bad = 0;

    always #5 clock_50 = ~clock_50;

    game_controller_p #(.MAX_ROUNDS(MR), .ROUND_W(5), .TIMEOUT(TO), .TIME_W(8), .LIVES(1)) dut0 (
        .clock_50(clock_50), .reset(reset), .enter(enter), .end_fpga(end_fpga),
        .end_user(end_user), .match(match),
        .r1(cmd0[6]), .r2(cmd0[5]), .e1(cmd0[4]), .e2(cmd0[3]), .e3(cmd0[2]),
        .e4(cmd0[1]), .sel(cmd0[0]),
        .round(rnd0), .lives_left(lv0), .timer(tmr0), .won(won0));

    game_controller_p #(.MAX_ROUNDS(MR), .ROUND_W(5), .TIMEOUT(TO), .TIME_W(8), .LIVES(3)) dut1 (
        .clock_50(clock_50), .reset(reset), .enter(enter), .end_fpga(end_fpga),
        .end_user(end_user), .match(match),
        .r1(cmd1[6]), .r2(cmd1[5]), .e1(cmd1[4]), .e2(cmd1[3]), .e3(cmd1[2]),
        .e4(cmd1[1]), .sel(cmd1[0]),
        .round(rnd1), .lives_left(lv1), .timer(tmr1), .won(won1));

    // ---------------- reference model (one game per instance) ----------------
    localparam int G_INIT = 0, G_SETUP = 1, G_FPGA = 2, G_USER = 3,
                   G_CHECK = 4, G_NEXT = 5, G_RETRY = 6, G_RESULT = 7;
    localparam logic [6:0] CMD_OF [8] = '{7'b1100000, 7'b0010000, 7'b0000100, 7'b0001000,
                                          7'b0000010, 7'b0100000, 7'b0100000, 7'b0000001};
    int  m_ph [2];
    int  m_round [2];
    int  m_lives [2];
    int  m_timer [2];
    int  m_won [2];
    int  m_eq;
    int  lives_cfg [2] = '{1, 3};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = G_INIT; m_round[k] = 0; m_lives[k] = lives_cfg[k];
            m_timer[k] = 0; m_won[k] = 0;
        end
        m_eq = 0;
    endtask

    task automatic model_miss(input int k);
        if (m_lives[k] > 1) m_ph[k] = G_RETRY;
        else begin
            m_ph[k] = G_RESULT; m_won[k] = 0; m_lives[k] = 0;
        end
    endtask

    // One clock edge of play, given the inputs present at that edge.
    task automatic model_edge();
        int rise;
        rise = (enter && !m_eq) ? 1 : 0;
        m_eq = enter ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
            case (m_ph[k])
                G_INIT: begin
                    m_round[k] = 0; m_lives[k] = lives_cfg[k]; m_won[k] = 0;
                    m_ph[k] = G_SETUP;
                end
                G_SETUP:  if (rise != 0) m_ph[k] = G_FPGA;
                G_FPGA:   if (end_fpga) m_ph[k] = G_USER;
                G_USER: begin
                    // the turn allows TO cycles: timer values 0..TO-1
                    if (m_timer[k] == TO - 1) model_miss(k);
                    else if (end_user) m_ph[k] = G_CHECK;
                    else m_timer[k]++;
                end
                G_CHECK:  if (match) m_ph[k] = G_NEXT; else model_miss(k);
                G_NEXT: begin
                    if (m_round[k] < MR) m_round[k]++;
                    if (m_round[k] == MR) begin m_ph[k] = G_RESULT; m_won[k] = 1; end
                    else m_ph[k] = G_FPGA;
                end
                G_RETRY: begin m_lives[k]--; m_ph[k] = G_FPGA; end
                default:  if (rise != 0) m_ph[k] = G_INIT;
            endcase
            if (m_ph[k] != G_USER) m_timer[k] = 0;
        end
    endtask

    task automatic compare_all();
        chk("d0.cmd", 32'(cmd0), 32'(CMD_OF[m_ph[0]]));
        chk("d0.round", 32'(rnd0), m_round[0]);
        chk("d0.lives", 32'(lv0), m_lives[0]);
        chk("d0.timer", 32'(tmr0), m_timer[0]);
        chk("d0.won", 32'(won0), m_won[0]);
        chk("d1.cmd", 32'(cmd1), 32'(CMD_OF[m_ph[1]]));
        chk("d1.round", 32'(rnd1), m_round[1]);
        chk("d1.lives", 32'(lv1), m_lives[1]);
        chk("d1.timer", 32'(tmr1), m_timer[1]);
        chk("d1.won", 32'(won1), m_won[1]);
    endtask

    // Drive inputs, take one edge, then check 1 time unit later.
    task automatic cycle(input logic en, input logic ef, input logic eu, input logic m);
        enter = en; end_fpga = ef; end_user = eu; match = m;
        @(posedge clock_50);
        model_edge();
        #1;
        compare_all();
    endtask

    // Async reset in the middle of a cycle; values must change immediately.
    task automatic apply_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst.r1r2", 32'(cmd0[6:5]), 32'd3);
        chk("rst.e2", 32'(cmd1[3]), 32'd0);
        chk("rst.timer", 32'(tmr1), 32'd0);
        model_reset();
        compare_all();
        @(posedge clock_50);
        #1;
        compare_all();
        reset = 1'b1;
    endtask

    initial begin
        enter = 1'b1;
        #2 reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clock_50);
        #1 reset = 1'b1;

        // enter held through reset release must not start the game
        repeat (10) cycle(1, 0, 0, 0);
        chk("hold_setup", 32'(cmd0[4]), 32'd1);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("start_fpga", 32'(cmd0[2]), 32'd1);

        // three clean rounds -> win
        for (int r = 0; r < MR; r++) begin
            cycle(0, 1, 0, 0);
            cycle(0, 0, 1, 0);
            cycle(0, 0, 0, 1);
            chk("next_r2", 32'(cmd0[5]), 32'd1);
            cycle(0, 0, 0, 0);
            chk("round_cnt", 32'(rnd0), 32'(r + 1));
        end
        chk("win_won", 32'(won0), 32'd1);
        chk("win_sel", 32'(cmd1[0]), 32'd1);

        // restart, then a first-round mismatch
        cycle(1, 0, 0, 0);
        chk("init_r1r2", 32'(cmd0[6:5]), 32'd3);
        cycle(0, 0, 0, 0);
        chk("setup_e1", 32'(cmd0[4]), 32'd1);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        chk("miss_lives0", 32'(lv0), 32'd0);
        chk("miss_won0", 32'(won0), 32'd0);
        chk("retry_r2", 32'(cmd1[5]), 32'd1);
        cycle(0, 0, 0, 0);
        chk("retry_lives", 32'(lv1), 32'd2);
        chk("retry_fpga", 32'(cmd1[2]), 32'd1);

        // timeout on the 3-life instance, end_user colliding with time_up
        cycle(0, 1, 0, 0);
        repeat (TO - 1) cycle(0, 0, 0, 0);
        chk("timer_max", 32'(tmr1), 32'(TO - 1));
        cycle(0, 0, 1, 0);
        chk("timeout_r2", 32'(cmd1[5]), 32'd1);
        chk("timeout_no_e4", 32'(cmd1[1]), 32'd0);
        cycle(0, 0, 0, 0);
        chk("lives_1", 32'(lv1), 32'd1);

        // reset mid user turn at timer 7
        cycle(0, 1, 0, 0);
        repeat (7) cycle(0, 0, 0, 0);
        chk("timer_7", 32'(tmr1), 32'd7);
        apply_reset();

        // randomized play
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) apply_reset();
            else cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                       ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
